// File: rtl/conv_accumulator_pkg.sv
// rtl/conv_accumulator_pkg.sv - shared constants and types for the convolution accumulator
//
// Holds the parameter defaults, the per-stage width growth of the adder
// tree, the channel group size, the pipeline latency and the sideband
// record that travels with every beat.
package conv_accumulator_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NUM_CH     = 64;
  localparam int DEF_ACC_WIDTH  = 32;

  // Growth over DATA_WIDTH after each tree level: 9 products, then
  // 8 channels, then 8 groups.
  localparam int S1_GROWTH = 4;
  localparam int S2_GROWTH = 7;
  localparam int S3_GROWTH = 10;

  localparam int S1_WIDTH = DEF_DATA_WIDTH + S1_GROWTH;
  localparam int S2_WIDTH = DEF_DATA_WIDTH + S2_GROWTH;
  localparam int S3_WIDTH = DEF_DATA_WIDTH + S3_GROWTH;

  localparam int GROUP_SIZE = 8;
  localparam int LATENCY    = 4;

  // Control bits sampled with the products and carried down the pipe.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
    logic relu;
  } side_t;

endpackage

// File: rtl/conv_accumulator_sum9_reg.sv
// rtl/conv_accumulator_sum9_reg.sv - registered 9-input signed adder for one channel
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   products   : 9 signed DATA_WIDTH products, product 0 in the MSBs
//   sum        : registered signed sum, DATA_WIDTH+4 bits
module sum9_reg
  import conv_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [DATA_WIDTH*9-1:0]            products,
  output logic signed [DATA_WIDTH+S1_GROWTH-1:0] sum
);

  localparam int SW = DATA_WIDTH + S1_GROWTH;

  logic signed [SW-1:0] sum_next;

  always_comb begin
    sum_next = '0;
    for (int k = 0; k < 9; k++) begin
      sum_next = sum_next + SW'($signed(products[DATA_WIDTH*9-1-DATA_WIDTH*k -: DATA_WIDTH]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum <= '0;
    else        sum <= sum_next;
  end

endmodule

// File: rtl/conv_accumulator.sv
// rtl/conv_accumulator.sv - pipelined 576-product adder tree with cross-pass accumulator
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   in_valid       : multiply holds one beat this cycle
//   first_pass     : beat starts a new accumulation
//   last_pass      : beat ends the accumulation and yields a result
//   relu_en, bias  : result post-processing, used with last_pass
//   multiply       : NUM_CH x 9 signed products, channel 0 in the MSBs
//   out_valid      : one-cycle result strobe
//   out_data       : signed result, out_sat flags DATA_WIDTH clamping
module conv_accumulator
  import conv_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  input  logic                             first_pass,
  input  logic                             last_pass,
  input  logic                             relu_en,
  input  logic signed [DATA_WIDTH-1:0]     bias,
  input  logic [DATA_WIDTH*9*NUM_CH-1:0]   multiply,
  output logic                             out_valid,
  output logic signed [DATA_WIDTH-1:0]     out_data,
  output logic                             out_sat
);

  localparam int S1W        = DATA_WIDTH + S1_GROWTH;
  localparam int S2W        = DATA_WIDTH + S2_GROWTH;
  localparam int S3W        = DATA_WIDTH + S3_GROWTH;
  localparam int NUM_GROUPS = NUM_CH / GROUP_SIZE;

  side_t                       s1_side, s2_side, s3_side;
  logic signed [DATA_WIDTH-1:0] s1_bias, s2_bias, s3_bias;
  logic signed [S1W-1:0]       s1_sum [NUM_CH];
  logic signed [S2W-1:0]       s2_next [NUM_GROUPS];
  logic signed [S2W-1:0]       s2_sum [NUM_GROUPS];
  logic signed [S3W-1:0]       s3_next, s3_tree;
  logic signed [ACC_WIDTH-1:0] acc;

  // Stage 1: one registered 9-input adder per channel.
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    sum9_reg #(.DATA_WIDTH(DATA_WIDTH)) u_sum9 (
      .clk      (clk),
      .rst_n    (rst_n),
      .products (multiply[DATA_WIDTH*9*NUM_CH-1-DATA_WIDTH*9*ch -: DATA_WIDTH*9]),
      .sum      (s1_sum[ch])
    );
  end

  // Stage 2 and 3 adders.
  always_comb begin
    for (int g = 0; g < NUM_GROUPS; g++) begin
      s2_next[g] = '0;
      for (int j = 0; j < GROUP_SIZE; j++) begin
        s2_next[g] = s2_next[g] + S2W'(s1_sum[g*GROUP_SIZE+j]);
      end
    end
  end

  always_comb begin
    s3_next = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      s3_next = s3_next + S3W'(s2_sum[g]);
    end
  end

  // Saturate an ACC_WIDTH+1 sum back to ACC_WIDTH: overflow shows as the
  // two top bits disagreeing.
  function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [ACC_WIDTH:0] w);
    if (w[ACC_WIDTH] != w[ACC_WIDTH-1])
      return w[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    return w[ACC_WIDTH-1:0];
  endfunction

  // Stage 4 datapath: accumulate, add bias, clamp to DATA_WIDTH, then ReLU.
  logic signed [ACC_WIDTH-1:0]       acc_new, res_acc;
  logic [ACC_WIDTH-DATA_WIDTH:0]     res_upper;
  logic signed [DATA_WIDTH-1:0]      res_dw;
  logic                              res_sat;

  always_comb begin
    if (s3_side.first) acc_new = ACC_WIDTH'(s3_tree);
    else               acc_new = sat_acc((ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(s3_tree));
    res_acc   = sat_acc((ACC_WIDTH+1)'(acc_new) + (ACC_WIDTH+1)'(s3_bias));
    // Fits in DATA_WIDTH when every bit from the DATA_WIDTH sign bit up matches.
    res_upper = res_acc[ACC_WIDTH-1:DATA_WIDTH-1];
    res_sat   = !((&res_upper) || !(|res_upper));
    if (res_sat)
      res_dw = res_acc[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      res_dw = res_acc[DATA_WIDTH-1:0];
    if (s3_side.relu && res_dw[DATA_WIDTH-1]) res_dw = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_side   <= '0;
      s2_side   <= '0;
      s3_side   <= '0;
      s1_bias   <= '0;
      s2_bias   <= '0;
      s3_bias   <= '0;
      for (int g = 0; g < NUM_GROUPS; g++) s2_sum[g] <= '0;
      s3_tree   <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      s1_side   <= '{valid: in_valid, first: first_pass, last: last_pass, relu: relu_en};
      s2_side   <= s1_side;
      s3_side   <= s2_side;
      s1_bias   <= bias;
      s2_bias   <= s1_bias;
      s3_bias   <= s2_bias;
      for (int g = 0; g < NUM_GROUPS; g++) s2_sum[g] <= s2_next[g];
      s3_tree   <= s3_next;
      out_valid <= s3_side.valid && s3_side.last;
      if (s3_side.valid) begin
        acc <= acc_new;
        if (s3_side.last) begin
          out_data <= res_dw;
          out_sat  <= res_sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_accumulator.sv
// tb/tb_conv_accumulator.sv - directed self-checking bench for conv_accumulator
module tb_conv_accumulator;
  import conv_accumulator_pkg::*;

  localparam int DW = 16;
  localparam int NC = 64;
  localparam int BW = DW * 9 * NC;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid, first_pass, last_pass, relu_en;
  logic signed [DW-1:0] bias;
  logic [BW-1:0]        multiply;
  logic                 out_valid;
  logic signed [DW-1:0] out_data;
  logic                 out_sat;

  conv_accumulator #(.DATA_WIDTH(DW), .NUM_CH(NC), .ACC_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .first_pass (first_pass),
    .last_pass  (last_pass),
    .relu_en    (relu_en),
    .bias       (bias),
    .multiply   (multiply),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sat    (out_sat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int beat_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic signed [DW-1:0] obs_data [$];
  logic                 obs_sat  [$];
  int                   obs_cyc  [$];

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      obs_data.push_back(out_data);
      obs_sat.push_back(out_sat);
      obs_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] fill(input logic signed [DW-1:0] p);
    logic [BW-1:0] v;
    for (int i = 0; i < 9 * NC; i++) v[i*DW +: DW] = p;
    return v;
  endfunction

  task automatic clear_obs();
    obs_data.delete();
    obs_sat.delete();
    obs_cyc.delete();
  endtask

  // Called at a negedge; drives one beat for one clock.
  task automatic beat(input logic signed [DW-1:0] p, input logic f, input logic l,
                      input logic r, input logic signed [DW-1:0] b);
    multiply   = fill(p);
    in_valid   = 1'b1;
    first_pass = f;
    last_pass  = l;
    relu_en    = r;
    bias       = b;
    beat_cyc   = cyc;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid   = 1'b0;
    first_pass = 1'b0;
    last_pass  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic signed [DW-1:0] p;
    logic                 relu;
    logic signed [DW-1:0] bias;
    logic signed [DW-1:0] exp_data;
    logic                 exp_sat;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{p: 16'sd1,      relu: 1'b1, bias: 16'sd0,     exp_data: 16'sd576,    exp_sat: 1'b0};
    vecs[1] = '{p: -16'sd1,     relu: 1'b1, bias: 16'sd0,     exp_data: 16'sd0,      exp_sat: 1'b0};
    vecs[2] = '{p: -16'sd1,     relu: 1'b0, bias: 16'sd0,     exp_data: -16'sd576,   exp_sat: 1'b0};
    vecs[3] = '{p: 16'sd32767,  relu: 1'b0, bias: 16'sd0,     exp_data: 16'sd32767,  exp_sat: 1'b1};
    vecs[4] = '{p: -16'sd32768, relu: 1'b0, bias: 16'sd0,     exp_data: -16'sd32768, exp_sat: 1'b1};
    vecs[5] = '{p: -16'sd32768, relu: 1'b1, bias: 16'sd0,     exp_data: 16'sd0,      exp_sat: 1'b1};
    vecs[6] = '{p: 16'sd10,     relu: 1'b0, bias: -16'sd6000, exp_data: -16'sd240,   exp_sat: 1'b0};
    vecs[7] = '{p: 16'sd56,     relu: 1'b0, bias: 16'sd511,   exp_data: 16'sd32767,  exp_sat: 1'b0};
    vecs[8] = '{p: 16'sd56,     relu: 1'b0, bias: 16'sd512,   exp_data: 16'sd32767,  exp_sat: 1'b1};
    vecs[9] = '{p: -16'sd56,    relu: 1'b0, bias: -16'sd512,  exp_data: -16'sd32768, exp_sat: 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0; first_pass = 1'b0; last_pass = 1'b0; relu_en = 1'b0;
    bias = '0; multiply = '0;
    repeat (3) @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_sat", out_sat, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-pass table.
    for (int i = 0; i < 10; i++) begin
      clear_obs();
      beat(vecs[i].p, 1'b1, 1'b1, vecs[i].relu, vecs[i].bias);
      idle(8);
      chk($sformatf("vec%0d result count", i), obs_data.size(), 1);
      if (obs_data.size() >= 1) begin
        chk($sformatf("vec%0d out_data", i), obs_data[0], vecs[i].exp_data);
        chk($sformatf("vec%0d out_sat", i), obs_sat[0], vecs[i].exp_sat);
        chk($sformatf("vec%0d latency", i), obs_cyc[0] - beat_cyc, LATENCY);
      end
    end

    // Two passes with bubbles between them; the bubbles carry junk control bits.
    clear_obs();
    beat(16'sd2, 1'b1, 1'b0, 1'b0, 16'sd0);
    multiply = fill(16'sd7); in_valid = 1'b0; first_pass = 1'b1; last_pass = 1'b1;
    repeat (2) @(negedge clk);
    beat(16'sd3, 1'b0, 1'b1, 1'b0, 16'sd100);
    idle(8);
    chk("two-pass result count", obs_data.size(), 1);
    if (obs_data.size() >= 1) begin
      chk("two-pass out_data", obs_data[0], 2980);
      chk("two-pass out_sat", obs_sat[0], 0);
    end

    // Continuing after a result builds on the retained acc (2880, bias excluded).
    clear_obs();
    beat(16'sd1, 1'b0, 1'b1, 1'b0, 16'sd0);
    idle(8);
    chk("retained acc count", obs_data.size(), 1);
    if (obs_data.size() >= 1) chk("retained acc out_data", obs_data[0], 3456);

    // Back-to-back single passes.
    clear_obs();
    for (int k = 1; k <= 4; k++) beat(DW'(k), 1'b1, 1'b1, 1'b0, 16'sd0);
    idle(8);
    chk("b2b result count", obs_data.size(), 4);
    if (obs_data.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("b2b%0d out_data", k), obs_data[k], 576 * (k + 1));
        chk($sformatf("b2b%0d cycle", k), obs_cyc[k] - obs_cyc[0], k);
      end
    end

    // Reset two cycles after a beat discards it.
    clear_obs();
    beat(16'sd5, 1'b1, 1'b1, 1'b0, 16'sd0);
    idle(1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid-reset out_valid", out_valid, 0);
    chk("mid-reset out_data", out_data, 0);
    chk("mid-reset out_sat", out_sat, 0);
    rst_n = 1'b1;
    idle(8);
    chk("post-reset result count", obs_data.size(), 0);
    chk("post-reset out_data", out_data, 0);
    chk("post-reset out_sat", out_sat, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
